// File: rtl/mem_lsu_pkg.sv
// Shared constants and state encoding for the mem_lsu load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Core request/response and word-memory signals of the load/store unit.
interface mem_lsu_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wr_en, mem_wr_data
    );

    // Core plus memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: load extraction/extension, store merge, access legality.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]            funct3,
    input  logic                  we,
    input  logic [1:0]            addr_lo,
    input  logic [LSU_DATA_W-1:0] word,
    input  logic [LSU_DATA_W-1:0] wdata,
    output logic [LSU_DATA_W-1:0] load_data,
    output logic [LSU_DATA_W-1:0] store_word,
    output logic                  illegal
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misaligned;
    logic        bad_f3;

    always_comb begin
        byte_sel = 8'(word >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        load_data = '0;
        unique case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase

        store_word = word;
        unique case (funct3)
            F3_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase

        // funct3[1:0] gives the access size for both signed and unsigned loads
        unique case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase

        if (we) bad_f3 = (funct3 >= 3'd3);
        else    bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);

        illegal = misaligned | bad_f3;
    end
endmodule

// File: rtl/mem_lsu.sv
// RV32I load/store unit: one request at a time, stores done as read-modify-write.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mem_lsu_if.slave   bus
);
    lsu_state_e            state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic                  is_idle;
    logic [2:0]            al_f3;
    logic                  al_we;
    logic [1:0]            al_lo;
    logic [DATA_WIDTH-1:0] al_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  illegal;

    // In IDLE the aligner judges the incoming request; afterwards it works on
    // the latched one, seeing the live read word in READ and the buffer later.
    always_comb begin
        is_idle = (state_q == IDLE);
        al_f3   = is_idle ? bus.req_funct3   : f3_q;
        al_we   = is_idle ? bus.req_we       : we_q;
        al_lo   = is_idle ? bus.req_addr[1:0] : addr_lo_q;
        al_word = (state_q == READ) ? bus.mem_rd_data : buf_q;
    end

    lsu_align u_align (
        .funct3     (al_f3),
        .we         (al_we),
        .addr_lo    (al_lo),
        .word       (al_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .illegal    (illegal)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        mem_addr_d   = mem_addr_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d      = bus.req_we;
                    f3_d      = bus.req_funct3;
                    addr_lo_d = bus.req_addr[1:0];
                    wdata_d   = bus.req_wdata;
                    if (illegal) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = READ;
                        mem_addr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
            end
            READ: begin
                buf_d = bus.mem_rd_data;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d    = IDLE;
                mem_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            mem_addr_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            mem_addr_q   <= mem_addr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready   = is_idle;
    assign bus.mem_wr_en   = (state_q == WRITE);
    assign bus.mem_wr_data = (state_q == WRITE) ? store_word : '0;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
endmodule
